// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug frame serializer slice:
//   - NB_BYTE          : width of one serial byte
//   - ST_IDLE/HEADER/SEND : serializer FSM state encoding
//   - clog2()          : ceiling log2 helper for elaboration-time widths
//   - bytes_per_frame(): number of serial bytes in one control frame
// -----------------------------------------------------------------------------
package debug_pkg;

  localparam int NB_BYTE = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // The frame width is expected to be an exact multiple of the byte width.
  function automatic int bytes_per_frame(input int nb_frame, input int nb_byte);
    return nb_frame / nb_byte;
  endfunction

endpackage

// File: rtl/debug_sync_fifo.sv
// -----------------------------------------------------------------------------
// debug_sync_fifo
// Single-clock FIFO with first-word-fall-through read: o_data always shows the
// oldest entry, and i_pop retires it at the clock edge. Push and pop in the
// same cycle are supported (count unchanged). The caller must not push while
// full without a same-cycle pop, nor pop while empty.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_push, i_data   : write strobe and data
//   i_pop            : retire the head entry
//   o_data           : head entry (valid while !o_empty)
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored entries (0..2**LOG2_DEPTH)
// -----------------------------------------------------------------------------
module debug_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [LOG2_DEPTH:0]   o_count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] rd_ptr_q;
  logic [LOG2_DEPTH:0]   count_q;

  // NOTE: storage has no reset; entries are only observed after being written,
  // so clearing them would cost a reset net per bit for nothing.
  always_ff @(posedge i_clock) begin
    if (i_push) mem[wr_ptr_q] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly LOG2_DEPTH bits wide, so they wrap modulo depth.
      if (i_push) wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
      if (i_pop)  rd_ptr_q <= rd_ptr_q + LOG2_DEPTH'(1);
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + (LOG2_DEPTH + 1)'(1);
        2'b01:   count_q <= count_q - (LOG2_DEPTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_data  = mem[rd_ptr_q];
  assign o_full  = (count_q == (LOG2_DEPTH + 1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/debug_frame_serializer.sv
// -----------------------------------------------------------------------------
// debug_frame_serializer
// Buffers NB_CONTROL_FRAME-bit debug frames (one per i_writing cycle, no
// upstream backpressure) and sends each as bytes, MSB byte first, over a
// valid/ready handshake to a UART transmitter.
// Optional feature macro: DEBUG_SERIALIZER_HEADER_EN -- when defined, each
// frame is preceded by one header byte holding an 8-bit wrapping sequence
// number that starts at 0 after reset.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_frame          : frame from the upstream latch stage
//   i_writing        : frame valid; each high cycle is one frame
//   i_tx_ready       : UART TX accepts a byte this cycle
//   o_tx_data        : byte to UART TX (0 while o_tx_valid is low)
//   o_tx_valid       : o_tx_data valid
//   o_busy           : FIFO non-empty or a frame is being sent
//   o_overflow       : sticky; at least one frame was dropped
// -----------------------------------------------------------------------------
module debug_frame_serializer #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_BYTE          = debug_pkg::NB_BYTE,
  parameter int LOG2_FIFO_DEPTH  = 3
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame,
  input  logic                        i_writing,
  input  logic                        i_tx_ready,
  output logic [NB_BYTE-1:0]          o_tx_data,
  output logic                        o_tx_valid,
  output logic                        o_busy,
  output logic                        o_overflow
);

  import debug_pkg::*;

  localparam int BPF   = bytes_per_frame(NB_CONTROL_FRAME, NB_BYTE);
  localparam int IDX_W = (BPF > 1) ? clog2(BPF) : 1;
  localparam int CNT_W = LOG2_FIFO_DEPTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPF - 1);

`ifdef DEBUG_SERIALIZER_HEADER_EN
  // A freshly loaded frame is announced by its header byte first.
  localparam logic [1:0] ST_LOAD = ST_HEADER;
`else
  localparam logic [1:0] ST_LOAD = ST_SEND;
`endif

  logic [1:0]                  state_q;
  logic [1:0]                  state_d;
  logic [NB_CONTROL_FRAME-1:0] shift_q;
  logic [IDX_W-1:0]            byte_idx_q;
  logic [NB_CONTROL_FRAME-1:0] fifo_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            fifo_count;
  logic [CNT_W-1:0]            count_next;
  logic                        push;
  logic                        pop;
  logic                        xfer;
  logic                        last_byte;
  logic                        overflow_q;
  logic                        busy_q;
`ifdef DEBUG_SERIALIZER_HEADER_EN
  logic [7:0]                  seq_q;
`endif

  debug_sync_fifo #(
    .WIDTH      (NB_CONTROL_FRAME),
    .LOG2_DEPTH (LOG2_FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (i_frame),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign xfer      = o_tx_valid & i_tx_ready;
  assign last_byte = (byte_idx_q == LAST_IDX);
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push       = i_writing & (~fifo_full | pop);
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and FIFO pop. A pop loads the shift register on the same edge,
  // which is what makes back-to-back frames gapless.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
`ifdef DEBUG_SERIALIZER_HEADER_EN
      ST_HEADER: begin
        if (xfer) state_d = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (xfer && last_byte) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so data holds while not ready.
  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state_q)
      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shift_q[NB_CONTROL_FRAME-1 -: NB_BYTE];
      end
`ifdef DEBUG_SERIALIZER_HEADER_EN
      ST_HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = NB_BYTE'(seq_q);
      end
`endif
      default: ;
    endcase
  end

  // Shift register and byte index. The index stops at the last byte; the
  // next load (or reset) brings it back to 0.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (pop) begin
      shift_q    <= fifo_data;
      byte_idx_q <= '0;
    end else if ((state_q == ST_SEND) && xfer && !last_byte) begin
      shift_q    <= shift_q << NB_BYTE;
      byte_idx_q <= byte_idx_q + IDX_W'(1);
    end
  end

`ifdef DEBUG_SERIALIZER_HEADER_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                           seq_q <= '0;
    else if ((state_q == ST_HEADER) && xfer) seq_q <= seq_q + 8'd1;
  end
`endif

  // Busy is registered from next-state values so it matches the state after
  // the edge and carries no combinational glitches.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (i_writing && fifo_full && !pop) overflow_q <= 1'b1;
      busy_q <= (state_d != ST_IDLE) || (count_next != '0);
    end
  end

  assign o_overflow = overflow_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_debug_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_debug_frame_serializer
// Self-checking bench for debug_frame_serializer with default parameters.
// A queue-based model (frames waiting, bytes of the frame in flight) predicts
// valid/data/busy/overflow every cycle; directed scenarios add literal byte
// sequences, then a randomized phase exercises mixed traffic and resets.
// Honours DEBUG_SERIALIZER_HEADER_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_debug_frame_serializer;

  localparam int NBF   = 32;
  localparam int NBB   = 8;
  localparam int LOG2D = 3;
  localparam int DEPTH = 8;
  localparam int BPF   = 4;
`ifdef DEBUG_SERIALIZER_HEADER_EN
  localparam int TXB = BPF + 1;
`else
  localparam int TXB = BPF;
`endif

  logic           i_clock;
  logic           i_reset;
  logic [NBF-1:0] i_frame;
  logic           i_writing;
  logic           i_tx_ready;
  logic [NBB-1:0] o_tx_data;
  logic           o_tx_valid;
  logic           o_busy;
  logic           o_overflow;

  debug_frame_serializer #(
    .NB_CONTROL_FRAME (NBF),
    .NB_BYTE          (NBB),
    .LOG2_FIFO_DEPTH  (LOG2D)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_frame    (i_frame),
    .i_writing  (i_writing),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frames waiting in the buffer, and the remaining bytes of
  // the frame currently being sent. A new frame is taken whenever nothing is
  // left in flight after this cycle's transfer.
  // ---------------------------------------------------------------------------
  logic [NBF-1:0] m_fifo[$];
  logic [7:0]     m_cur[$];
  logic           m_ovf;
  logic [7:0]     m_seq;
  logic           m_pop;
  logic           m_acc;
  logic [NBF-1:0] m_f;

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      m_fifo.delete();
      m_cur.delete();
      m_ovf = 1'b0;
      m_seq = 8'd0;
    end else begin
      if (m_cur.size() != 0 && i_tx_ready) void'(m_cur.pop_front());
      m_pop = (m_cur.size() == 0) && (m_fifo.size() != 0);
      m_acc = i_writing && ((m_fifo.size() < DEPTH) || m_pop);
      if (i_writing && !m_acc) m_ovf = 1'b1;
      if (m_pop) begin
        m_f = m_fifo.pop_front();
`ifdef DEBUG_SERIALIZER_HEADER_EN
        m_cur.push_back(m_seq);
        m_seq = m_seq + 8'd1;
`endif
        for (int b = 0; b < BPF; b++) m_cur.push_back(m_f[NBF-1-8*b -: 8]);
      end
      if (m_acc) m_fifo.push_back(i_frame);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      check("tx_valid", o_tx_valid, m_cur.size() != 0);
      if (m_cur.size() != 0) check("tx_data", o_tx_data, m_cur[0]);
      check("busy", o_busy, (m_cur.size() != 0) || (m_fifo.size() != 0));
      check("overflow", o_overflow, m_ovf);
    end
  end

  // Log of bytes actually handed over, for the literal expectations.
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  always @(negedge i_clock) begin
    if (!i_reset && o_tx_valid && i_tx_ready) cap_q.push_back(o_tx_data);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_writing = 1'b0;
    i_reset   = 1'b1;
    #2;
    check("rst_tx_valid", o_tx_valid, 1'b0);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);
    step();
    step();
    i_reset = 1'b0;
    cap_q.delete();
  endtask

  task automatic write_frame(input logic [NBF-1:0] f);
    i_frame   = f;
    i_writing = 1'b1;
    step();
    i_writing = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((o_busy || o_tx_valid) && n < max_cycles) begin
      step();
      n++;
    end
    check({name, "_drained"}, o_busy, 1'b0);
  endtask

  task automatic check_cap(input string name);
    check({name, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check({name, "_byte"}, cap_q[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wps[6];
    int rps[6];
    wps = '{10, 50, 90, 30, 100, 5};
    rps = '{90, 30, 60, 10, 100, 50};

    i_reset    = 1'b1;
    i_frame    = '0;
    i_writing  = 1'b0;
    i_tx_ready = 1'b0;
    do_reset();

    // Single frame: valid appears two cycles after the write cycle.
    i_tx_ready = 1'b1;
    write_frame(32'hDEADBEEF);
    check("single_lat_n1", o_tx_valid, 1'b0);
    step();
    check("single_lat_n2", o_tx_valid, 1'b1);
    drain("single", 50);
`ifdef DEBUG_SERIALIZER_HEADER_EN
    exp_q = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`else
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
`endif
    check_cap("single");

    // Backpressure: ready pattern 1,0,0,1 repeating.
    do_reset();
    i_tx_ready = 1'b0;
    write_frame(32'hDEADBEEF);
    for (int i = 0; i < 40; i++) begin
      i_tx_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    i_tx_ready = 1'b1;
    drain("bp", 50);
    check_cap("bp");

    // Back-to-back frames with ready held high.
    do_reset();
    i_tx_ready = 1'b1;
    write_frame(32'h01020304);
    write_frame(32'h05060708);
    write_frame(32'h090A0B0C);
    drain("b2b", 100);
`ifdef DEBUG_SERIALIZER_HEADER_EN
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h02, 8'h09, 8'h0A, 8'h0B, 8'h0C};
`else
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C};
`endif
    check_cap("b2b");

    // Overflow: with ready low, frame 1 is already loaded into the shift
    // register when frame 2 arrives, so frames 2..9 fill the 8-entry FIFO and
    // only frame 10 is dropped: 9 frames leave once ready rises.
    do_reset();
    i_tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_frame(32'hA0000000 + i);
    step();
    check("ovf_set", o_overflow, 1'b1);
    i_tx_ready = 1'b1;
    drain("ovf", 200);
    check("ovf_sticky", o_overflow, 1'b1);
    check("ovf_bytes", cap_q.size(), 9 * TXB);

    // Full FIFO with a same-cycle pop: the write on the last-byte transfer
    // is accepted and no overflow is flagged.
    do_reset();
    i_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) write_frame(32'hB0000000 + i);
    step();
    check("fwp_no_ovf_pre", o_overflow, 1'b0);
    i_tx_ready = 1'b1;
    repeat (TXB - 1) step();
    write_frame(32'hCAFEF00D);
    check("fwp_no_ovf", o_overflow, 1'b0);
    drain("fwp", 200);
    check("fwp_bytes", cap_q.size(), 10 * TXB);
    if (cap_q.size() >= 4) begin
      check("fwp_last0", cap_q[cap_q.size()-4], 8'hCA);
      check("fwp_last3", cap_q[cap_q.size()-1], 8'h0D);
    end

    // Reset in the middle of a frame with more frames queued.
    do_reset();
    i_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_frame(32'h11223344 + i);
    step();
    i_tx_ready = 1'b1;
    step();
    step();
    #3;
    do_reset();
    i_tx_ready = 1'b1;
    repeat (20) step();
    check("mid_rst_no_bytes", cap_q.size(), 0);
    check("mid_rst_busy", o_busy, 1'b0);

    // Randomized traffic with occasional resets.
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 599) == 0) do_reset();
        i_frame    = $urandom;
        i_writing  = ($urandom_range(0, 99) < wps[seg]);
        i_tx_ready = ($urandom_range(0, 99) < rps[seg]);
        step();
      end
    end
    i_writing  = 1'b0;
    i_tx_ready = 1'b1;
    drain("rand", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
